// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared mode constants and default tap masks for lfsr_gen.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    localparam int LFSR_FIB = 0;
    localparam int LFSR_GAL = 1;

    // Maximal-length masks for the common widths
    localparam logic [3:0]  LFSR_TAPS_4  = 4'hC;
    localparam logic [7:0]  LFSR_TAPS_8  = 8'h8E;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

endpackage
`default_nettype wire

// File: rtl/lfsr_next.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_next
// Description : Combinational LFSR next-state function (Fibonacci or Galois).
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_8,
    parameter int               MODE  = LFSR_FIB
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] nxt
);

    generate
        if (MODE == LFSR_GAL) begin : g_galois
            logic w_fb;
            assign w_fb   = state[WIDTH-1];
            assign nxt[0] = w_fb;
            // Top tap bit has no destination and is ignored
            for (genvar i = 1; i < WIDTH; i++) begin : g_gal_bit
                assign nxt[i] = state[i-1] ^ (w_fb & TAPS[i-1]);
            end
        end else begin : g_fibonacci
            assign nxt = {state[WIDTH-2:0], ^(state & TAPS)};
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/lfsr_gen.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_gen
// Description : Parametrised LFSR generator with seed load, lock-up recovery
//               and period tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_8,
    parameter logic [WIDTH-1:0] SEED  = 8'hBD,
    parameter int               MODE  = LFSR_FIB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             bit_out,
    output logic [WIDTH-1:0] step_cnt,
    output logic             period_done,
    output logic             lockup
);

    generate
        if (WIDTH < 3 || WIDTH > 32) begin : g_width_check
            $error("lfsr_gen: WIDTH must be within 3..32");
        end
        if (SEED == '0) begin : g_seed_check
            $error("lfsr_gen: SEED must be non-zero");
        end
    endgenerate

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_ref;
    logic [WIDTH-1:0] r_cnt;
    logic             r_period_done;
    logic             r_lockup;
    logic [WIDTH-1:0] w_nxt;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .MODE  (MODE)
    ) u_next (
        .state (r_state),
        .nxt   (w_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= SEED;
            r_ref         <= SEED;
            r_cnt         <= '0;
            r_period_done <= 1'b0;
            r_lockup      <= 1'b0;
        end else begin
            r_period_done <= 1'b0;
            r_lockup      <= 1'b0;
            if (load) begin
                r_state <= load_val;
                r_ref   <= load_val;
                r_cnt   <= '0;
            end else if (r_state == '0) begin
                // All-zero state never advances on its own; recover to SEED
                r_state  <= SEED;
                r_ref    <= SEED;
                r_cnt    <= '0;
                r_lockup <= 1'b1;
            end else if (en) begin
                r_state <= w_nxt;
                if (w_nxt == r_ref) begin
                    r_period_done <= 1'b1;
                    r_cnt         <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign out         = r_state;
    assign bit_out     = r_state[WIDTH-1];
    assign step_cnt    = r_cnt;
    assign period_done = r_period_done;
    assign lockup      = r_lockup;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_gen
// Description : Self-checking bench for lfsr_gen, Fibonacci and Galois
//               instances driven in parallel against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_gen;

    localparam logic [7:0] c_TAPS = 8'h8E;
    localparam logic [7:0] c_SEED = 8'hBD;

    logic       r_clk = 1'b0;
    logic       r_rst = 1'b0;
    logic       r_en = 1'b0;
    logic       r_load = 1'b0;
    logic [7:0] r_load_val = 8'h00;

    logic [7:0] w_out [2];
    logic       w_bit [2];
    logic [7:0] w_cnt [2];
    logic       w_pd  [2];
    logic       w_lk  [2];

    // Model state, index 0 = Fibonacci, 1 = Galois
    logic [7:0] m_s [2];
    logic [7:0] m_r [2];
    logic [7:0] m_c [2];
    logic       m_pd [2];
    logic       m_lk [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 r_clk = ~r_clk;

    lfsr_gen #(.WIDTH(8), .TAPS(c_TAPS), .SEED(c_SEED), .MODE(0)) dut_fib (
        .clk(r_clk), .rst(r_rst), .en(r_en), .load(r_load), .load_val(r_load_val),
        .out(w_out[0]), .bit_out(w_bit[0]), .step_cnt(w_cnt[0]),
        .period_done(w_pd[0]), .lockup(w_lk[0])
    );

    lfsr_gen #(.WIDTH(8), .TAPS(c_TAPS), .SEED(c_SEED), .MODE(1)) dut_gal (
        .clk(r_clk), .rst(r_rst), .en(r_en), .load(r_load), .load_val(r_load_val),
        .out(w_out[1]), .bit_out(w_bit[1]), .step_cnt(w_cnt[1]),
        .period_done(w_pd[1]), .lockup(w_lk[1])
    );

    // Fibonacci: shift left, parity of tapped bits enters at the bottom.
    // Galois: shift left; if the bit shifted out was 1, XOR in (TAPS<<1)|1.
    function automatic logic [7:0] model_next(input int mode, input logic [7:0] s);
        int v;
        v = (int'(s) << 1) & 255;
        if (mode == 0)
            v = v | ($countones(s & c_TAPS) % 2);
        else if (s[7])
            v = v ^ (((int'(c_TAPS) << 1) | 1) & 255);
        return v[7:0];
    endfunction

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst_i, input logic load_i,
                              input logic [7:0] lv, input logic en_i);
        logic [7:0] n;
        for (int m = 0; m < 2; m++) begin
            if (rst_i) begin
                m_s[m] = c_SEED; m_r[m] = c_SEED; m_c[m] = 8'd0;
                m_pd[m] = 1'b0;  m_lk[m] = 1'b0;
            end else begin
                m_pd[m] = 1'b0;
                m_lk[m] = 1'b0;
                if (load_i) begin
                    m_s[m] = lv; m_r[m] = lv; m_c[m] = 8'd0;
                end else if (m_s[m] == 8'd0) begin
                    m_s[m] = c_SEED; m_r[m] = c_SEED; m_c[m] = 8'd0; m_lk[m] = 1'b1;
                end else if (en_i) begin
                    n = model_next(m, m_s[m]);
                    m_s[m] = n;
                    if (n == m_r[m]) begin
                        m_pd[m] = 1'b1;
                        m_c[m]  = 8'd0;
                    end else begin
                        m_c[m] = m_c[m] + 8'd1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            chk8(m == 0 ? "fib_out" : "gal_out", w_out[m], m_s[m]);
            chk1(m == 0 ? "fib_bit_out" : "gal_bit_out", w_bit[m], m_s[m][7]);
            chk8(m == 0 ? "fib_step_cnt" : "gal_step_cnt", w_cnt[m], m_c[m]);
            chk1(m == 0 ? "fib_period_done" : "gal_period_done", w_pd[m], m_pd[m]);
            chk1(m == 0 ? "fib_lockup" : "gal_lockup", w_lk[m], m_lk[m]);
        end
    endtask

    // Apply inputs, take one rising edge, then check 1 time unit later
    task automatic step(input logic rst_i, input logic load_i,
                        input logic [7:0] lv, input logic en_i);
        r_rst = rst_i; r_load = load_i; r_load_val = lv; r_en = en_i;
        @(posedge r_clk);
        model_edge(rst_i, load_i, lv, en_i);
        #1;
        compare_all();
    endtask

    bit seen [256];
    int n_unique;

    initial begin
        // Reset
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk8("rst_out_fib", w_out[0], 8'hBD);
        chk8("rst_out_gal", w_out[1], 8'hBD);
        chk8("rst_cnt", w_cnt[0], 8'd0);
        chk1("rst_pd", w_pd[0], 1'b0);
        chk1("rst_lockup", w_lk[0], 1'b0);

        // One full period from SEED in both modes
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            seen[w_out[1]] = 1'b1;
            if (i == 1) begin
                chk8("fib_step1", w_out[0], 8'h7B);
                chk8("gal_step1", w_out[1], 8'h67);
            end
            if (i == 2) chk8("fib_step2", w_out[0], 8'hF6);
            if (i < 255) begin
                chk8("fib_cnt_run", w_cnt[0], i[7:0]);
                chk1("fib_pd_early", w_pd[0], 1'b0);
                chk1("gal_pd_early", w_pd[1], 1'b0);
            end else begin
                chk1("fib_pd_255", w_pd[0], 1'b1);
                chk1("gal_pd_255", w_pd[1], 1'b1);
                chk8("fib_out_255", w_out[0], 8'hBD);
                chk8("gal_out_255", w_out[1], 8'hBD);
                chk8("fib_cnt_255", w_cnt[0], 8'd0);
            end
        end
        n_unique = 0;
        for (int i = 1; i < 256; i++) if (seen[i]) n_unique++;
        chk_int("gal_unique_values", n_unique, 255);
        chk1("gal_zero_unseen", seen[0], 1'b0);

        // Load zero: one cycle of zero, then automatic reseed
        step(1'b0, 1'b1, 8'h00, 1'b1);
        chk8("load0_out", w_out[0], 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk8("reseed_out", w_out[0], 8'hBD);
        chk1("reseed_lockup", w_lk[0], 1'b1);
        chk8("reseed_cnt", w_cnt[0], 8'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk1("lockup_pulse_end", w_lk[0], 1'b0);

        // Load mid-sequence with en high: load wins, new reference
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h5A, 1'b1);
        chk8("load5a_out", w_out[0], 8'h5A);
        chk8("load5a_cnt", w_cnt[0], 8'd0);
        for (int i = 1; i <= 255; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            if (i == 255) begin
                chk1("load5a_pd_fib", w_pd[0], 1'b1);
                chk8("load5a_out_fib", w_out[0], 8'h5A);
                chk1("load5a_pd_gal", w_pd[1], 1'b1);
                chk8("load5a_out_gal", w_out[1], 8'h5A);
            end
        end

        // Random enable with rare loads
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(63) == 0)
                step(1'b0, 1'b1, 8'($urandom_range(255)), 1'($urandom_range(1)));
            else
                step(1'b0, 1'b0, 8'h00, 1'($urandom_range(1)));
        end

        // Reset together with load and en: reset wins
        step(1'b1, 1'b1, 8'h33, 1'b1);
        chk8("rst_load_out", w_out[0], 8'hBD);
        chk8("rst_load_cnt", w_cnt[0], 8'd0);
        chk1("rst_load_pd", w_pd[0], 1'b0);
        chk1("rst_load_lk", w_lk[0], 1'b0);
        for (int i = 1; i <= 255; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk1("post_rst_pd", w_pd[0], 1'b1);
        chk8("post_rst_out", w_out[0], 8'hBD);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
